// File: rtl/dec_cntr.sv
// Free-running modulo-MODULUS up-counter with a registered binary output.
// Wraps MODULUS-1 -> 0; any out-of-range value also recovers to 0 on the next edge.
module dec_cntr #(
    parameter int MODULUS = 1000,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    generate
        if (MODULUS < 2) begin : g_bad_modulus
            $error("dec_cntr: MODULUS must be at least 2");
        end
        if (WIDTH < 32 && (longint'(1) << WIDTH) < longint'(MODULUS)) begin : g_bad_width
            $error("dec_cntr: WIDTH too narrow to hold MODULUS-1");
        end
    endgenerate

    // The declaration initialiser sets the power-on value, so the output is
    // 0 even before the first reset edge.
    logic [WIDTH-1:0] cnt = '0;

    // Compare with >= rather than == so a corrupted value cannot run on
    // past the top of the range.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its inputs from before the edge, independent of block order.
        if (rst) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign out = cnt;

endmodule

// File: tb/tb_dec_cntr.sv
// Directed self-checking bench for dec_cntr: reset, glitch immunity, wrap,
// full-period sequence, mid-count reset and reset coincident with the wrap.
module tb_dec_cntr;

    localparam int MODULUS = 1000;
    localparam int WIDTH   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] out;

    int checks = 0;
    int errors = 0;

    dec_cntr #(.MODULUS(MODULUS), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .out(out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, out=%0d required finish", out);
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out !== 32'd0) begin
            errors++;
            $display("FAIL power_on: out=%0d required=0", out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out=%0d required=0", i, out);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (out !== 32'(i)) begin
                errors++;
                $display("FAIL reset_release[%0d]: out=%0d required=%0d", i, out, i);
            end
        end
    endtask

    task automatic test_glitch();
        // Counter sits at 3 here; two more edges reach 5.
        step();
        step();
        checks++;
        if (out !== 32'd5) begin
            errors++;
            $display("FAIL glitch_setup: out=%0d required=5", out);
        end
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        checks++;
        if (out !== 32'd5) begin
            errors++;
            $display("FAIL glitch_hold: out=%0d required=5", out);
        end
        step();
        checks++;
        if (out !== 32'd6) begin
            errors++;
            $display("FAIL glitch_next: out=%0d required=6", out);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (999) step();
        checks++;
        if (out !== 32'd999) begin
            errors++;
            $display("FAIL wrap_top: out=%0d required=999", out);
        end
        step();
        checks++;
        if (out !== 32'd0) begin
            errors++;
            $display("FAIL wrap_zero: out=%0d required=0", out);
        end
        step();
        checks++;
        if (out !== 32'd1) begin
            errors++;
            $display("FAIL wrap_one: out=%0d required=1", out);
        end
    endtask

    task automatic test_full_period();
        int bad = 0;
        apply_reset();
        for (int i = 1; i <= 2000; i++) begin
            step();
            checks++;
            if (out !== 32'(i % MODULUS) || out > 32'd999) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL period[%0d]: out=%0d required=%0d", i, out, i % MODULUS);
            end
        end
        checks++;
        if (out !== 32'd0) begin
            errors++;
            $display("FAIL period_end: out=%0d required=0", out);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (57) step();
        checks++;
        if (out !== 32'd57) begin
            errors++;
            $display("FAIL mid_setup: out=%0d required=57", out);
        end
        apply_reset();
        // apply_reset leaves us at the negedge after the reset edge.
        checks++;
        if (out !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: out=%0d required=0", out);
        end
        step();
        checks++;
        if (out !== 32'd1) begin
            errors++;
            $display("FAIL mid_release: out=%0d required=1", out);
        end
    endtask

    task automatic test_reset_at_wrap();
        apply_reset();
        repeat (999) step();
        checks++;
        if (out !== 32'd999) begin
            errors++;
            $display("FAIL rwrap_setup: out=%0d required=999", out);
        end
        apply_reset();
        checks++;
        if (out !== 32'd0) begin
            errors++;
            $display("FAIL rwrap_reset: out=%0d required=0", out);
        end
        step();
        checks++;
        if (out !== 32'd1) begin
            errors++;
            $display("FAIL rwrap_release: out=%0d required=1", out);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wrap();
        test_full_period();
        test_mid_reset();
        test_reset_at_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
